screen_addr_responder: RTL
==========================

# screen_addr_responder

Hardware-side responder for the Nios screen-reader address port. It takes the 20-bit screen address driven by the Nios address PIO and a request level from a companion PIO bit. It reads the addressed pixel word from the frame-buffer RAM and returns the word with a four-phase req/ack handshake that the Nios polls through an input PIO. It sits between the Nios PIO outputs and the read port of the oscilloscope frame buffer.

## Interface
Parameters:
- ADDR_W, 20: width of the screen address.
- DATA_W, 16: pixel word width.
- FB_WORDS, 307200: number of valid frame-buffer words (640x480).
- RD_LATENCY, 2: fixed frame-buffer read latency in cycles, range 1..4.

Ports:
- clk  in  1  system clock; the block uses one clock only.
- reset  in  1  synchronous, active-high reset.
- addr_in  in  ADDR_W  screen address from the Nios address PIO.
- req  in  1  request level from the Nios control PIO.
- fb_addr  out  ADDR_W  frame-buffer read address.
- fb_rd  out  1  frame-buffer read strobe, one cycle per read.
- fb_rdata  in  DATA_W  frame-buffer read data, valid RD_LATENCY cycles after the fb_rd cycle.
- rdata  out  DATA_W  returned pixel word.
- ack  out  1  handshake acknowledge.
- err  out  1  the last request was out of range.

## Operation
- Reset values: fb_addr=0, fb_rd=0, rdata=0, ack=0, err=0. The FSM resets to IDLE. The latency pipe and any prefetch state are cleared, and in-flight RAM data is discarded.
- FSM states: IDLE, READ, ACK.
- IDLE:
  - Stays in IDLE while req=0.
  - When req=1, latches addr_in into addr_q.
  - If addr_in >= FB_WORDS: sets rdata=0 and err=1, then goes to ACK. No RAM access.
  - Otherwise: drives fb_rd=1 and fb_addr=addr_in on the next cycle, then goes to READ.
- READ: counts RD_LATENCY cycles and captures fb_rdata into rdata. Sets err=0, then goes to ACK.
- ACK:
  - ack=1 while in this state.
  - When req is sampled 0, ack drops the next cycle and the FSM returns to IDLE.
  - rdata and err hold their values until the next capture.
- A change on addr_in while in READ or ACK is ignored, because the address is latched.
- If req falls before ack rises, the transaction still completes; ack is high for exactly one cycle.
- Address compare is unsigned at ADDR_W bits. FB_WORDS-1 is the last valid address.

## Timing
- Let cycle t be the cycle in which IDLE samples req=1.
- In-range read: fb_rd is high in cycle t+1, fb_rdata is captured at t+1+RD_LATENCY, and ack rises at t+2+RD_LATENCY. With the default latency this is t+4.
- Out-of-range request: ack and err rise at t+1.
- Release: req sampled 0 in cycle u gives ack=0 at u+1. A new request is accepted no earlier than u+1.
- fb_rd is never high for two consecutive cycles for the same transaction.

## Configuration
- Macro: SCREEN_ADDR_RESPONDER_PREFETCH_EN.
- Defined:
  - On entering ACK after an in-range read, the block issues one prefetch read of addr_q+1. It does so only if addr_q+1 < FB_WORDS.
  - The result is stored in pf_data/pf_addr with pf_valid=1.
  - On the next request, if pf_valid=1 and addr_in==pf_addr, ack and rdata are presented at t+1 with no RAM read. This counts as a hit and the block then prefetches again.
  - If the request arrives while a prefetch is still in flight, IDLE waits for that data to land, then does the hit check.
  - A miss invalidates pf_valid and takes the normal READ path.
- Undefined: no prefetch logic, and every request takes the READ path.

## Structure
- Package screen_addr_responder_pkg holds:
  - the FSM state enum;
  - the default FB_WORDS constant;
  - a max-latency constant (4) for sizing the pipe.
- One sub-module: screen_addr_responder_rdpipe. It is a RD_LATENCY-deep valid shift register that tags each fb_rd as demand or prefetch, and it is cleared by reset.

## Test plan
- Reset, then req=1 with addr_in=0x00010. The RAM model returns 0xABCD. Required: fb_rd high at t+1 with fb_addr=0x00010, ack=1 at t+4, rdata=0xABCD, err=0. After req drops, ack=0 one cycle later.
- addr_in=307200 (0x4B000): ack and err rise at t+1, rdata=0, and fb_rd is never asserted.
- addr_in=307199: normal read, err=0. Then addr_in=307200: err=1.
- req pulsed for one cycle only: ack is high for exactly one cycle at t+4. addr_in changed to 0x00020 during READ: fb_addr stays 0x00010.
- Reset asserted in the cycle after fb_rd: ack stays 0, the late fb_rdata is not captured, and the next request completes normally.
- With the prefetch macro defined:
  - Read addr 5, then request addr 6: ack at t+1 with the word at addr 6, and no demand fb_rd.
  - Then request addr 9: miss, with ack at t+4.

Source files
------------

// File: rtl/screen_addr_responder_pkg.sv
// Shared types and constants for the screen address responder.
package screen_addr_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACK
    } state_e;

    localparam int FB_WORDS_DEFAULT = 307200;
    localparam int MAX_RD_LATENCY   = 4;

    // Keeps the read pipe depth inside the supported 1..MAX_RD_LATENCY range.
    function automatic int clamp_latency(input int lat);
        if (lat < 1) return 1;
        if (lat > MAX_RD_LATENCY) return MAX_RD_LATENCY;
        return lat;
    endfunction

endpackage

// File: rtl/screen_addr_responder_rdpipe.sv
// Read-latency pipe: follows each fb_rd for LATENCY cycles and tags it as
// demand (tag=0) or prefetch (tag=1), so the top knows when and what data lands.
module screen_addr_responder_rdpipe
    import screen_addr_responder_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic tag,
    output logic out_valid,
    output logic out_tag
);

    localparam int DEPTH = clamp_latency(LATENCY);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] tag_sr;

    // NOTE: non-blocking assignments make every stage read its neighbour's old value, giving a true shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr <= '0;
            tag_sr   <= '0;
        end else begin
            valid_sr[0] <= issue;
            tag_sr[0]   <= tag;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                tag_sr[i]   <= tag_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_tag   = tag_sr[DEPTH-1];

endmodule

// File: rtl/screen_addr_responder.sv
// Screen address responder: Nios PIO address/req in, frame-buffer word out over a four-phase req/ack.
// Optional next-address prefetch is enabled with `define SCREEN_ADDR_RESPONDER_PREFETCH_EN.
module screen_addr_responder
    import screen_addr_responder_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int FB_WORDS   = FB_WORDS_DEFAULT,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              req,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [DATA_W-1:0] fb_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err
);

    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

    state_e state;
    logic   fb_pf;
    logic   pf_wait;
    logic   pipe_valid;
    logic   pipe_pf;

    screen_addr_responder_rdpipe #(
        .LATENCY(RD_LATENCY)
    ) u_rdpipe (
        .clk      (clk),
        .reset    (reset),
        .issue    (fb_rd),
        .tag      (fb_pf),
        .out_valid(pipe_valid),
        .out_tag  (pipe_pf)
    );

`ifdef SCREEN_ADDR_RESPONDER_PREFETCH_EN
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pf_addr;
    logic [DATA_W-1:0] pf_data;
    logic [ADDR_W-1:0] next_q;
    logic [ADDR_W-1:0] next_in;
    logic              pf_valid;
    logic              pf_pending;
    logic              pf_hit;

    assign next_q  = addr_q + ADDR_W'(1);
    assign next_in = addr_in + ADDR_W'(1);
    assign pf_wait = pf_pending;
    assign pf_hit  = pf_valid && (addr_in == pf_addr);

    // NOTE: pf_data needs no reset; it is never used unless pf_valid, which is reset.
    always_ff @(posedge clk) begin
        if (pipe_valid && pipe_pf) pf_data <= fb_rdata;
    end
`else
    assign fb_pf   = 1'b0;
    assign pf_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            fb_addr <= '0;
            fb_rd   <= 1'b0;
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
`ifdef SCREEN_ADDR_RESPONDER_PREFETCH_EN
            addr_q     <= '0;
            pf_addr    <= '0;
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
            fb_pf      <= 1'b0;
`endif
        end else begin
            fb_rd <= 1'b0;
`ifdef SCREEN_ADDR_RESPONDER_PREFETCH_EN
            if (pipe_valid && pipe_pf) begin
                pf_valid   <= 1'b1;
                pf_pending <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    // A request arriving while a prefetch is in flight waits for it to land.
                    if (req && !pf_wait) begin
`ifdef SCREEN_ADDR_RESPONDER_PREFETCH_EN
                        addr_q   <= addr_in;
                        pf_valid <= 1'b0;
                        if (pf_hit) begin
                            rdata <= pf_data;
                            err   <= 1'b0;
                            ack   <= 1'b1;
                            state <= ACK;
                            if (next_in < FB_LIMIT) begin
                                fb_rd      <= 1'b1;
                                fb_pf      <= 1'b1;
                                fb_addr    <= next_in;
                                pf_addr    <= next_in;
                                pf_pending <= 1'b1;
                            end
                        end else
`endif
                        if (addr_in >= FB_LIMIT) begin
                            rdata <= '0;
                            err   <= 1'b1;
                            ack   <= 1'b1;
                            state <= ACK;
                        end else begin
                            fb_rd   <= 1'b1;
                            fb_addr <= addr_in;
`ifdef SCREEN_ADDR_RESPONDER_PREFETCH_EN
                            fb_pf   <= 1'b0;
`endif
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (pipe_valid && !pipe_pf) begin
                        rdata <= fb_rdata;
                        err   <= 1'b0;
                        ack   <= 1'b1;
                        state <= ACK;
`ifdef SCREEN_ADDR_RESPONDER_PREFETCH_EN
                        if (next_q < FB_LIMIT) begin
                            fb_rd      <= 1'b1;
                            fb_pf      <= 1'b1;
                            fb_addr    <= next_q;
                            pf_addr    <= next_q;
                            pf_pending <= 1'b1;
                        end
`endif
                    end
                end
                ACK: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
